// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
// Holds the op encodings, the default busy durations and the controller
// state type. Any block that drives the MDU op input imports this package
// so both sides agree on the encodings.
package mdu_pkg;

  // Op encodings; codes 6 and 7 are reserved and behave as NOP.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic isLongOp(input logic [2:0] opCode);
    return (opCode == OP_MULT) || (opCode == OP_MULTU) ||
           (opCode == OP_DIV)  || (opCode == OP_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [2:0] opCode);
    return (opCode == OP_DIV) || (opCode == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu -- MIPS-style multiply/divide unit with HI/LO result registers.
// A long op (MULT/MULTU/DIV/DIVU) is latched on acceptance, the unit stays
// busy for a fixed number of cycles, and the combinational result of the
// latched operands is committed to HI/LO on the edge where busy drops.
// MTHI/MTLO write HI/LO directly in the accepting edge without going busy.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   start - one-cycle request to launch the op on 'op' (ignored while busy)
//   op    - operation code (mdu_pkg::op_e)
//   a     - operand rs; write data for MTHI/MTLO
//   b     - operand rt
//   busy  - registered, high while a long op is in flight
//   hi    - HI register
//   lo    - LO register
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e         r_state;
  state_e         w_nextState;
  logic           r_busy;
  logic [CW-1:0]  r_count;
  logic [2:0]     r_op;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;

  logic           w_accept;
  logic           w_mtHi;
  logic           w_mtLo;
  logic           w_done;

  logic [63:0]    w_prodS;
  logic [63:0]    w_prodU;
  logic [31:0]    w_divisor;
  logic [32:0]    w_dvdS;
  logic [32:0]    w_dvsS;
  logic [32:0]    w_quotS;
  logic [32:0]    w_remS;
  logic [31:0]    w_quotU;
  logic [31:0]    w_remU;
  logic [31:0]    w_resHi;
  logic [31:0]    w_resLo;
  logic           w_commit;

  // State register; busy is registered from the next state so it rises on
  // the accepting edge and falls on the expiry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState == ST_RUN);
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start && isLongOp(op)) w_nextState = ST_RUN;
      ST_RUN:  if (r_count == '0)         w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Controller outputs. Requests only count in IDLE, so a start while busy
  // touches nothing.
  always_comb begin
    w_accept = 1'b0;
    w_mtHi   = 1'b0;
    w_mtLo   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = start && isLongOp(op);
        w_mtHi   = start && (op == OP_MTHI);
        w_mtLo   = start && (op == OP_MTLO);
      end
      ST_RUN: w_done = (r_count == '0);
      default: ;
    endcase
  end

  // Operand latch and cycle counter. The counter is loaded with N-1 so that
  // busy covers exactly N cycles: the commit happens on the edge that sees 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_a     <= a;
      r_b     <= b;
      r_count <= isDivOp(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
    end else if ((r_state == ST_RUN) && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Result arithmetic on the latched operands. Signed division runs in 33
  // bits so 0x80000000 / -1 yields +2^31 (low word 0x80000000, remainder 0)
  // instead of overflowing. A zero divisor is replaced by 1 to keep the
  // dividers defined; that result is never committed.
  assign w_prodS   = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prodU   = {32'd0, r_a} * {32'd0, r_b};
  assign w_divisor = (r_b == 32'd0) ? 32'd1 : r_b;
  assign w_dvdS    = {r_a[31], r_a};
  assign w_dvsS    = {w_divisor[31], w_divisor};
  assign w_quotS   = $signed(w_dvdS) / $signed(w_dvsS);
  assign w_remS    = $signed(w_dvdS) % $signed(w_dvsS);
  assign w_quotU   = r_a / w_divisor;
  assign w_remU    = r_a % w_divisor;

  // Select the result for the latched op; divide by zero leaves HI/LO alone.
  always_comb begin
    w_resHi  = r_hi;
    w_resLo  = r_lo;
    w_commit = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_resHi  = w_prodS[63:32];
        w_resLo  = w_prodS[31:0];
        w_commit = 1'b1;
      end
      OP_MULTU: begin
        w_resHi  = w_prodU[63:32];
        w_resLo  = w_prodU[31:0];
        w_commit = 1'b1;
      end
      OP_DIV: begin
        w_resHi  = w_remS[31:0];
        w_resLo  = w_quotS[31:0];
        w_commit = (r_b != 32'd0);
      end
      OP_DIVU: begin
        w_resHi  = w_remU;
        w_resLo  = w_quotU;
        w_commit = (r_b != 32'd0);
      end
      default: ;
    endcase
  end

  // HI/LO registers: written at long-op expiry or by an accepted MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done && w_commit) begin
      r_hi <= w_resHi;
      r_lo <= w_resLo;
    end else begin
      if (w_mtHi) r_hi <= a;
      if (w_mtLo) r_lo <= a;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- self-checking bench for the multiply/divide unit.
// A behavioural model tracks the expected busy/HI/LO every cycle, and the
// directed sequence pins hand-computed results for the notable cases.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = DEF_MULT_CYCLES;
  localparam int DIV_N  = DEF_DIV_CYCLES;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic in plain integer terms, returned as {hi, lo}.
  function automatic logic [63:0] modelResult(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p  = '0;
    case (o)
      OP_MULT:  p = 64'(sx * sy);
      OP_MULTU: p = {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y != 0) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: if (y != 0) p = {x % y, x / y};
      default: p = '0;
    endcase
    return p;
  endfunction

  // Model: cycles left busy, the pending result and whether it will land.
  int          mLeft = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [63:0] mPend = '0;
  logic        mPendValid = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLeft      <= 0;
      mHi        <= '0;
      mLo        <= '0;
      mPendValid <= 1'b0;
    end else if (mLeft > 0) begin
      if (mLeft == 1 && mPendValid) begin
        mHi <= mPend[63:32];
        mLo <= mPend[31:0];
      end
      mLeft <= mLeft - 1;
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          mLeft      <= MULT_N;
          mPend      <= modelResult(op, a, b);
          mPendValid <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          mLeft      <= DIV_N;
          mPend      <= modelResult(op, a, b);
          mPendValid <= (b != 32'd0);
        end
        OP_MTHI: mHi <= a;
        OP_MTLO: mLo <= a;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (busy !== (mLeft > 0) || hi !== mHi || lo !== mLo) begin
        errors++;
        $display("[TB] FAIL model t=%0t busy=%0b exp %0b hi=%h exp %h lo=%h exp %h",
                 $time, busy, (mLeft > 0), hi, mHi, lo, mLo);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: presents the request for one cycle, then
  // scrambles the inputs to show the operands were latched.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts busy cycles from the current falling edge; returns at the first
  // falling edge with busy low.
  task automatic runAndCount(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout busy still %b after %0d cycles", busy, n);
    end
  endtask

  int n;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #1 reset = 1'b1;

    @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    // Release reset and request MULT for the very next edge.
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    runAndCount(n);
    checkOutput("mult_cycles", 32'(n), 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runAndCount(n);
    checkOutput("multu_cycles", 32'(n), 32'd5);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    runAndCount(n);
    checkOutput("div_cycles", 32'(n), 32'd10);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    // MTHI/MTLO then divide by zero keeps the moved values.
    applyStimulus(OP_MTHI, 32'h11, 32'd0);
    checkOutput("mthi_busy", 32'(busy), 32'd0);
    checkOutput("mthi_hi", hi, 32'h11);
    applyStimulus(OP_MTLO, 32'h22, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h22);
    applyStimulus(OP_DIVU, 32'd5, 32'd0);
    runAndCount(n);
    checkOutput("div0_cycles", 32'(n), 32'd10);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runAndCount(n);
    checkOutput("divovf_lo", lo, 32'h8000_0000);
    checkOutput("divovf_hi", hi, 32'h0);

    // MTLO in busy cycle 2 must be ignored.
    applyStimulus(OP_MULT, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MTLO;
    a     = 32'h99;
    @(negedge clk);
    start = 1'b0;
    runAndCount(n);
    checkOutput("busystart_remaining", 32'(n), 32'd3);
    checkOutput("busystart_hi", hi, 32'h0);
    checkOutput("busystart_lo", lo, 32'd6);

    // Back-to-back: start in the first idle cycle.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    runAndCount(n);
    checkOutput("b2b_cycles", 32'(n), 32'd10);
    checkOutput("b2b_hi", hi, 32'd2);
    checkOutput("b2b_lo", lo, 32'd14);

    // Reserved codes are NOPs.
    applyStimulus(OP_NOP6, 32'hDEAD, 32'hBEEF);
    applyStimulus(OP_NOP7, 32'h1234, 32'h5678);
    checkOutput("nop_busy", 32'(busy), 32'd0);
    checkOutput("nop_hi", hi, 32'd2);
    checkOutput("nop_lo", lo, 32'd14);

    // Reset in busy cycle 4 of DIV 100/7, then MULT 4*5.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(OP_MULT, 32'd4, 32'd5);
    runAndCount(n);
    checkOutput("postreset_cycles", 32'(n), 32'd5);
    checkOutput("postreset_lo", lo, 32'd20);
    checkOutput("postreset_hi", hi, 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("hold_lo", lo, 32'd20);
    checkOutput("hold_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
